// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: word-to-bit sequencer for the serial 0010110 Moore recognizer.
// Accepts W-bit words over valid/ready, feeds them MSB-first into the
// recognizer, counts reported matches and returns the count over valid/ready.
module seq_scan_ctrl #(
  parameter int unsigned W          = 8,
  parameter int unsigned CW         = $clog2(W + 1),
  parameter bit          CLEAR_EACH = 1'b0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] match_cnt,
  output logic          busy,
  output logic          rec_x,
  output logic          rec_en,
  output logic          rec_clr,
  input  logic          rec_z
);

  localparam int unsigned BW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t         state;
  logic [W-1:0]   sreg;
  logic [BW-1:0]  bitcnt;
  logic           out_valid_q;

  // Sequencer: load word, shift it out, collect the trailing result, hand off count.
  // rec_z in the first SHIFT cycle (bitcnt==W) still reflects the previous
  // bit/word, so sampling starts one cycle late and DRAIN picks up the last bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      sreg        <= '0;
      bitcnt      <= '0;
      match_cnt   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sreg      <= in_data;
            bitcnt    <= BW'(W);
            match_cnt <= '0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          sreg   <= {sreg[W-2:0], 1'b0};
          bitcnt <= bitcnt - BW'(1);
          if ((bitcnt != BW'(W)) && rec_z) begin
            match_cnt <= match_cnt + CW'(1);
          end
          if (bitcnt == BW'(1)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (rec_z) begin
            match_cnt <= match_cnt + CW'(1);
          end
          out_valid_q <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake and recognizer controls; reset forces the quiescent values immediately.
  always_comb begin
    in_ready  = (state == IDLE) && !reset;
    busy      = ((state == SHIFT) || (state == DRAIN)) && !reset;
    rec_en    = (state == SHIFT) && !reset;
    rec_x     = (state == SHIFT) ? sreg[W-1] : 1'b0;
    rec_clr   = reset || (CLEAR_EACH && in_valid && (state == IDLE));
    out_valid = out_valid_q && !reset;
  end

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// tb_seq_scan_ctrl: directed bench for seq_scan_ctrl (W=8). Two instances run in
// lockstep on shared stimulus, one with CLEAR_EACH=1 and one with CLEAR_EACH=0,
// each driving its own behavioural 0010110 recognizer.
module tb_seq_scan_ctrl;

  logic       clock;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;

  logic       in_ready1, out_valid1, busy1, rec_x1, rec_en1, rec_clr1, rec_z1;
  logic       in_ready0, out_valid0, busy0, rec_x0, rec_en0, rec_clr0, rec_z0;
  logic [3:0] cnt1, cnt0;

  int unsigned rs1, rs0;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;

  seq_scan_ctrl #(.W(8), .CW(4), .CLEAR_EACH(1'b1)) dut1 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
    .match_cnt(cnt1), .busy(busy1), .rec_x(rec_x1), .rec_en(rec_en1),
    .rec_clr(rec_clr1), .rec_z(rec_z1)
  );

  seq_scan_ctrl #(.W(8), .CW(4), .CLEAR_EACH(1'b0)) dut0 (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
    .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
    .match_cnt(cnt0), .busy(busy0), .rec_x(rec_x0), .rec_en(rec_en0),
    .rec_clr(rec_clr0), .rec_z(rec_z0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Overlapping Moore recognizer for 0010110; state = matched prefix length.
  function automatic int unsigned nxt(input int unsigned s, input logic b);
    case (s)
      0: return b ? 0 : 1;
      1: return b ? 0 : 2;
      2: return b ? 3 : 2;
      3: return b ? 0 : 4;
      4: return b ? 5 : 2;
      5: return b ? 6 : 1;
      6: return b ? 0 : 7;
      7: return b ? 0 : 2;
      default: return 0;
    endcase
  endfunction

  always @(posedge clock) begin
    if (rec_clr1) rs1 <= 0; else if (rec_en1) rs1 <= nxt(rs1, rec_x1);
    if (rec_clr0) rs0 <= 0; else if (rec_en0) rs0 <= nxt(rs0, rec_x0);
  end
  assign rec_z1 = (rs1 == 7);
  assign rec_z0 = (rs0 == 7);

  // Reference count of matches over one word, MSB first, from a given start state.
  task automatic ref_count(input logic [7:0] w, input int unsigned s_in,
                           output int cnt, output int unsigned s_out);
    int unsigned s;
    s   = s_in;
    cnt = 0;
    for (int i = 7; i >= 0; i--) begin
      s = nxt(s, w[i]);
      if (s == 7) cnt++;
    end
    s_out = s;
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One word through both instances: accept, shift, drain, optional hold, release.
  task automatic run_word(input logic [7:0] d, input int e1, input int e0,
                          input int hold, input string tag);
    int         en1, en0;
    logic [7:0] xs;
    en1 = 0;
    en0 = 0;
    xs  = '0;
    in_data  = d;
    in_valid = 1'b1;
    #1;
    chk({tag, "_in_ready1"}, in_ready1, 1);
    chk({tag, "_in_ready0"}, in_ready0, 1);
    chk({tag, "_rec_clr1"}, rec_clr1, 1);
    chk({tag, "_rec_clr0"}, rec_clr0, 0);
    tick();
    in_valid = 1'b0;
    in_data  = ~d;
    for (int c = 1; c <= 9; c++) begin
      if (rec_en1) begin
        xs = {xs[6:0], rec_x1};
        en1++;
      end
      if (rec_en0) en0++;
      if (c == 9) begin
        chk({tag, "_drain_busy"}, busy1, 1);
        chk({tag, "_drain_ov"}, out_valid1, 0);
      end
      tick();
    end
    chk({tag, "_rec_en_cycles1"}, en1, 8);
    chk({tag, "_rec_en_cycles0"}, en0, 8);
    chk({tag, "_rec_x_bits"}, xs, d);
    chk({tag, "_out_valid1"}, out_valid1, 1);
    chk({tag, "_out_valid0"}, out_valid0, 1);
    chk({tag, "_cnt_clear1"}, cnt1, e1);
    chk({tag, "_cnt_carry0"}, cnt0, e0);
    chk({tag, "_done_busy"}, busy1, 0);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_data  = ~d;
      #1;
      chk({tag, "_hold_ov"}, out_valid1, 1);
      chk({tag, "_hold_cnt"}, cnt1, e1);
      chk({tag, "_hold_in_ready"}, in_ready1, 0);
      chk({tag, "_hold_rec_clr"}, rec_clr1, 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "_idle_in_ready"}, in_ready1, 1);
    chk({tag, "_idle_ov"}, out_valid1, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  w [4];
    int          e1, e0, n, acc, prev, ovseen;
    int unsigned ms0, ms1, dummy;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    tick();
    tick();
    chk("R_rec_clr", rec_clr1, 1);
    chk("R_in_ready", in_ready1, 0);
    chk("R_out_valid", out_valid1, 0);
    chk("R_busy", busy1, 0);
    chk("R_rec_en", rec_en1, 0);
    reset = 1'b0;
    #1;
    chk("R_post_in_ready", in_ready1, 1);
    chk("R_post_cnt", cnt1, 0);
    chk("R_post_rec_clr", rec_clr1, 0);

    // Single match, then no-match words
    run_word(8'b0010_1100, 1, 1, 0, "T2");
    run_word(8'hFF, 0, 0, 0, "T3ff");
    run_word(8'h00, 0, 0, 0, "T3zero");

    // Carry-over across words
    run_word(8'b0000_0010, 0, 0, 0, "T4a");
    run_word(8'b1100_0000, 0, 1, 0, "T4b");
    // Match on the last bit; stale rec_z at next word's first SHIFT must not count
    run_word(8'b0001_0110, 1, 1, 0, "T4c");
    run_word(8'hFF, 0, 0, 0, "T4d");

    // Back-pressure in DONE
    run_word(8'b0010_1100, 1, 1, 3, "T5");

    // Reset mid-SHIFT: carry instance pre-loaded to prefix 001011
    run_word(8'b0000_1011, 0, 0, 0, "T1pre");
    in_data  = 8'h40;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("T1_mid_cnt0", cnt0, 1);
    chk("T1_mid_busy", busy1, 1);
    reset = 1'b1;
    #1;
    chk("T1_rst_rec_clr1", rec_clr1, 1);
    chk("T1_rst_rec_clr0", rec_clr0, 1);
    chk("T1_rst_in_ready", in_ready1, 0);
    chk("T1_rst_busy", busy0, 0);
    chk("T1_rst_rec_en", rec_en0, 0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("T1_idle_in_ready", in_ready0, 1);
    chk("T1_idle_cnt0", cnt0, 0);
    chk("T1_idle_ov", out_valid0, 0);
    chk("T1_idle_busy", busy0, 0);
    ovseen = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid0 || out_valid1) ovseen = 1;
      tick();
    end
    chk("T1_no_out_valid", ovseen, 0);
    run_word(8'b0010_1100, 1, 1, 0, "T1post");

    // Streaming with both handshakes held high
    ms0 = 2;
    for (int k = 0; k < 4; k++) w[k] = 8'($urandom);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      in_data = w[k];
      #1;
      n = 0;
      while (!in_ready1 && n < 20) begin
        tick();
        n++;
      end
      chk("T6_accept_timeout", in_ready1, 1);
      acc = cyc;
      if (k > 0) chk("T6_period", acc - prev, 11);
      prev = acc;
      ms1 = 0;
      ref_count(w[k], ms1, e1, dummy);
      ref_count(w[k], ms0, e0, ms0);
      tick();
      in_data = ~w[k];
      n = 0;
      while (!out_valid1 && n < 20) begin
        tick();
        n++;
      end
      chk("T6_out_valid_timeout", out_valid1, 1);
      chk("T6_latency", cyc - acc, 10);
      chk("T6_cnt_clear1", cnt1, e1);
      chk("T6_cnt_carry0", cnt0, e0);
      if (k == 3) in_valid = 1'b0;
      tick();
    end
    out_ready = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
